uart_result_tx: RTL and testbench

//  Serial back-end of the core: consumes the 16-bit ALU result produced by the FSM stage
//  and transmits it as UART 8N1 frames on a single pin (uio_out[0] at top level).

---
 rtl/uart_result_tx_pkg.sv | 19 +
 rtl/uart_result_tx_if.sv | 12 +
 rtl/uart_baud_tick.sv | 31 +++
 rtl/uart_result_tx.sv | 125 ++++++++++++
 tb/tb_uart_result_tx.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/uart_result_tx_pkg.sv
// Shared types and constants for the UART result transmitter.
package uart_result_tx_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StData  = 2'd2,
    StStop  = 2'd3
  } tx_state_e;

  localparam int unsigned DefaultClksPerBit = 1042;
  localparam logic        UartIdle          = 1'b1;

  // Baud counter width; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned clks);
    return (clks > 2) ? $clog2(clks) : 1;
  endfunction

endpackage

// File: rtl/uart_result_tx_if.sv
// Request/status bundle between the FSM stage and the UART result transmitter.
interface uart_result_tx_if;
  logic        ena;
  logic        start;
  logic [15:0] data;
  logic        tx;
  logic        busy;
  logic        done;

  modport master (output ena, output start, output data, input tx, input busy, input done);
  modport slave  (input ena, input start, input data, output tx, output busy, output done);
endinterface

// File: rtl/uart_baud_tick.sv
// Bit-time counter: counts enabled cycles and flags the last cycle of each bit period.
module uart_baud_tick
  import uart_result_tx_pkg::*;
#(
  parameter int unsigned ClksPerBit = DefaultClksPerBit
) (
  input  logic clock,
  input  logic reset,
  input  logic i_en,
  input  logic i_clear,
  output logic o_tick
);

  localparam int unsigned    CntW    = cnt_width(ClksPerBit);
  localparam logic [CntW-1:0] TermCnt = CntW'(ClksPerBit - 1);

  logic [CntW-1:0] r_cnt;

  assign o_tick = i_en && !i_clear && (r_cnt == TermCnt);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= o_tick ? '0 : r_cnt + CntW'(1);
    end
  end

endmodule

// File: rtl/uart_result_tx.sv
// Sends the 16-bit ALU result as NumBytes UART 8N1 frames, low byte first, LSB first.
module uart_result_tx
  import uart_result_tx_pkg::*;
#(
  parameter int unsigned ClksPerBit = DefaultClksPerBit,
  parameter int unsigned NumBytes   = 2
) (
  input  logic             clock,
  input  logic             reset,
  uart_result_tx_if.slave  bus
);

  localparam logic LastByte = 1'(NumBytes - 1);

  tx_state_e  r_state, w_state_nxt;
  logic [2:0] r_bit, w_bit_nxt;
  logic       r_byte, w_byte_nxt;
  logic [7:0] r_shift, w_shift_nxt;
  logic [7:0] r_hi, w_hi_nxt;
  logic       r_tx, w_tx_nxt;
  logic       r_busy, w_busy_nxt;
  logic       r_done, w_done_nxt;
  logic       w_tick;

  // Counter is held at zero while idle so the start bit begins a fresh bit period.
  uart_baud_tick #(
    .ClksPerBit (ClksPerBit)
  ) u_baud (
    .clock   (clock),
    .reset   (reset),
    .i_en    (bus.ena),
    .i_clear (r_state == StIdle),
    .o_tick  (w_tick)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= StIdle;
      r_bit   <= '0;
      r_byte  <= 1'b0;
      r_shift <= '0;
      r_hi    <= '0;
      r_tx    <= UartIdle;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_bit   <= w_bit_nxt;
      r_byte  <= w_byte_nxt;
      r_shift <= w_shift_nxt;
      r_hi    <= w_hi_nxt;
      r_tx    <= w_tx_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_bit_nxt   = r_bit;
    w_byte_nxt  = r_byte;
    w_shift_nxt = r_shift;
    w_hi_nxt    = r_hi;
    w_tx_nxt    = r_tx;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    if (bus.ena) begin
      unique case (r_state)
        StIdle: begin
          w_tx_nxt = UartIdle;
          if (bus.start) begin
            w_hi_nxt    = bus.data[15:8];
            w_shift_nxt = bus.data[7:0];
            w_byte_nxt  = 1'b0;
            w_bit_nxt   = '0;
            w_state_nxt = StStart;
            w_busy_nxt  = 1'b1;
            w_tx_nxt    = 1'b0;
          end
        end
        StStart: begin
          if (w_tick) begin
            w_state_nxt = StData;
            w_bit_nxt   = '0;
            w_tx_nxt    = r_shift[0];
          end
        end
        StData: begin
          if (w_tick) begin
            if (r_bit == 3'd7) begin
              w_state_nxt = StStop;
              w_tx_nxt    = 1'b1;
            end else begin
              w_bit_nxt   = r_bit + 3'd1;
              w_shift_nxt = {1'b0, r_shift[7:1]};
              w_tx_nxt    = r_shift[1];
            end
          end
        end
        StStop: begin
          if (w_tick) begin
            // Next byte starts straight after the stop bit, no gap.
            if (r_byte != LastByte) begin
              w_byte_nxt  = r_byte + 1'b1;
              w_shift_nxt = r_hi;
              w_state_nxt = StStart;
              w_tx_nxt    = 1'b0;
            end else begin
              w_state_nxt = StIdle;
              w_busy_nxt  = 1'b0;
              w_done_nxt  = 1'b1;
              w_tx_nxt    = UartIdle;
            end
          end
        end
        default: w_state_nxt = StIdle;
      endcase
    end
  end

  assign bus.tx   = r_tx;
  assign bus.busy = r_busy;
  assign bus.done = r_done;

endmodule

// File: tb/tb_uart_result_tx.sv
// Randomised bench for uart_result_tx: line-level model of two instances (2 bytes, 1 byte).
module tb_uart_result_tx;
  import uart_result_tx_pkg::*;

  localparam int C = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ena   = 1'b0;
  logic        start = 1'b0;
  logic [15:0] data  = '0;

  int tests = 0;
  int fails = 0;

  logic [19:0] lit2 = 20'b1101001010_1001111000;
  logic [9:0]  lit6 = 10'b1001101000;

  uart_result_tx_if bus0 ();
  uart_result_tx_if bus1 ();

  assign bus0.ena   = ena;
  assign bus0.start = start;
  assign bus0.data  = data;
  assign bus1.ena   = ena;
  assign bus1.start = start;
  assign bus1.data  = data;

  uart_result_tx #(.ClksPerBit(C), .NumBytes(2)) dut0 (
    .clock (clock),
    .reset (reset),
    .bus   (bus0.slave)
  );

  uart_result_tx #(.ClksPerBit(C), .NumBytes(1)) dut1 (
    .clock (clock),
    .reset (reset),
    .bus   (bus1.slave)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Line level at cycle p of a request: frames of 10 bit-slots, C cycles each.
  function automatic logic level(input logic [15:0] d, input int p);
    int fb;
    int slot;
    fb   = p / (10 * C);
    slot = (p % (10 * C)) / C;
    if (slot == 0) return 1'b0;
    if (slot == 9) return 1'b1;
    return d[8 * fb + slot - 1];
  endfunction

  // Model index k has 2-k bytes per request.
  logic        m_tx   [2];
  logic        m_busy [2];
  logic        m_done [2];
  int          m_pos  [2];
  logic [15:0] m_data [2];

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 2; k++) begin
        m_tx[k]   <= 1'b1;
        m_busy[k] <= 1'b0;
        m_done[k] <= 1'b0;
        m_pos[k]  <= 0;
        m_data[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        m_done[k] <= 1'b0;
        if (ena) begin
          if (m_busy[k]) begin
            if (m_pos[k] + 1 == 10 * C * (2 - k)) begin
              m_busy[k] <= 1'b0;
              m_done[k] <= 1'b1;
              m_tx[k]   <= 1'b1;
              m_pos[k]  <= 0;
            end else begin
              m_pos[k] <= m_pos[k] + 1;
              m_tx[k]  <= level(m_data[k], m_pos[k] + 1);
            end
          end else if (start) begin
            m_busy[k] <= 1'b1;
            m_data[k] <= data;
            m_pos[k]  <= 0;
            m_tx[k]   <= 1'b0;
          end
        end
      end
    end
  end

  always @(negedge clock) begin
    if (!reset) begin
      check("dut0_tx",   bus0.tx,   m_tx[0]);
      check("dut0_busy", bus0.busy, m_busy[0]);
      check("dut0_done", bus0.done, m_done[0]);
      check("dut1_tx",   bus1.tx,   m_tx[1]);
      check("dut1_busy", bus1.busy, m_busy[1]);
      check("dut1_done", bus1.done, m_done[1]);
    end
  end

  // One idle cycle, then drive a one-cycle start; returns at the accepting edge.
  task automatic send(input logic [15:0] d);
    @(posedge clock);
    #1;
    start = 1'b1;
    data  = d;
    ena   = 1'b1;
    @(posedge clock);
  endtask

  // Runs one two-byte request from its accepting edge through the done cycle.
  // pin: 1 = literal 0xA53C waveform on dut0, 2 = literal 0x34 frame on dut1.
  task automatic run_frame(input int lo, input int len, input bit stray, input bit chain,
                           input logic [15:0] nxt, input int pin);
    int d;
    d = 10 * C * 2 + len;
    for (int n = 0; n <= d; n++) begin
      #1;
      start = (chain && n == d) || (stray && (n == 10 || n == 40));
      if (chain && n == d) data = nxt;
      else if (start) data = 16'($urandom);
      ena = !(n >= lo && n < lo + len);
      @(negedge clock);
      check("busy_window", bus0.busy, n < d);
      check("done_edge",   bus0.done, n == d);
      if (pin == 1 && n < 80 && n % 4 == 1) check("frame_bit_a53c", bus0.tx, lit2[n / 4]);
      if (pin == 2) begin
        if (n < 40 && n % 4 == 1) check("frame_bit_34", bus1.tx, lit6[n / 4]);
        if (n >= 40) check("one_byte_idle", bus1.tx, 1'b1);
        check("one_byte_busy", bus1.busy, n < 40);
        check("one_byte_done", bus1.done, n == 40);
      end
      @(posedge clock);
    end
  endtask

  initial begin
    #12;
    reset = 1'b0;
    @(negedge clock);
    check("rst_tx",   bus0.tx,   1'b1);
    check("rst_busy", bus0.busy, 1'b0);
    check("rst_done", bus0.done, 1'b0);

    // Basic frame with stray starts at E+10 and E+40.
    send(16'hA53C);
    run_frame(0, 0, 1'b1, 1'b0, 16'h0000, 1);

    // ena low for 7 cycles inside data bit 3 of byte 0.
    send(16'hA53C);
    run_frame(17, 7, 1'b0, 1'b0, 16'h0000, 0);

    // Start in the done cycle chains a second request.
    send(16'h5A81);
    run_frame(0, 0, 1'b0, 1'b1, 16'h00FF, 0);
    run_frame(0, 0, 1'b0, 1'b0, 16'h0000, 0);

    // Single-byte instance sends only the low byte.
    repeat (45) @(posedge clock);
    send(16'h1234);
    run_frame(0, 0, 1'b0, 1'b0, 16'h0000, 2);

    for (int r = 0; r < 6; r++) begin
      int idle;
      idle = $urandom_range(0, 5);
      for (int i = 0; i < idle; i++) begin
        @(posedge clock);
        #1;
        start = 1'b0;
        ena   = 1'($urandom);
      end
      repeat (45) @(posedge clock);
      send(16'($urandom));
      run_frame($urandom_range(1, 60), $urandom_range(0, 12), 1'($urandom), 1'b0,
                16'h0000, 0);
    end

    // Async reset in the middle of byte 0 data.
    send(16'hC3F0);
    #1;
    start = 1'b0;
    repeat (18) @(posedge clock);
    @(negedge clock);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_tx",   bus0.tx,   1'b1);
    check("mid_rst_busy", bus0.busy, 1'b0);
    check("mid_rst_done", bus0.done, 1'b0);
    @(posedge clock);
    @(negedge clock);
    #2;
    reset = 1'b0;
    repeat (5) @(posedge clock);
    @(negedge clock);
    check("post_rst_idle", bus0.tx, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
